// File: rtl/uart_receiver_pkg.sv
// Shared definitions for the UART receive path: state encoding and the
// baud-timing helpers also used by the transmit side.
package uart_receiver_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } uart_rx_state_t;

  // Whole clk cycles per bit, rounded down.
  function automatic int calc_bit_period(input int clk_frequency, input int baud);
    return clk_frequency / baud;
  endfunction

  // Cycles from the start-bit edge to the start-bit centre, rounded down.
  function automatic int calc_half_period(input int bit_period);
    return bit_period / 2;
  endfunction

  // Counter width able to hold bit_period-1; never narrower than one bit.
  function automatic int calc_counter_width(input int bit_period);
    return (bit_period > 1) ? $clog2(bit_period) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous, idle-high input.
// Both stages reset to 1 so a reset never looks like a falling edge.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out
);

  logic meta;

  // Shift the raw input through two flops to settle metastability.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta     <= 1'b1;
      sync_out <= 1'b1;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: turns the asynchronous uart_rx line into one-cycle
// byte strobes in the clk domain. Samples each bit at its centre, counted
// from the first cycle the synchronised line is seen low.
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int comm_clk_frequency = 50_000_000,
  parameter int baud_rate          = 115_200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  output logic [7:0] rx_byte,
  output logic       rx_new_byte,
  output logic       framing_error,
  output logic       rx_busy
);

  localparam int BIT_PERIOD  = calc_bit_period(comm_clk_frequency, baud_rate);
  localparam int HALF_PERIOD = calc_half_period(BIT_PERIOD);
  localparam int CNT_W       = calc_counter_width(BIT_PERIOD);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_PERIOD - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'((HALF_PERIOD > 0) ? HALF_PERIOD - 1 : 0);

  logic           line;
  uart_rx_state_t state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [2:0]     bit_idx, bit_idx_next;
  logic [7:0]     shift, shift_next;
  logic [7:0]     rx_byte_next;
  logic           new_byte_next;
  logic           ferr_next;

  uart_rx_sync u_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (uart_rx),
    .sync_out (line)
  );

  assign rx_busy = (state != IDLE);

  // Register the FSM state, timing counters, data and output strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      shift         <= '0;
      rx_byte       <= '0;
      rx_new_byte   <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      bit_idx       <= bit_idx_next;
      shift         <= shift_next;
      rx_byte       <= rx_byte_next;
      rx_new_byte   <= new_byte_next;
      framing_error <= ferr_next;
    end
  end

  // Next-state logic: start-bit qualification, centre sampling, stop check.
  always_comb begin
    state_next    = state;
    cnt_next      = cnt + CNT_W'(1);
    bit_idx_next  = bit_idx;
    shift_next    = shift;
    rx_byte_next  = rx_byte;
    new_byte_next = 1'b0;
    ferr_next     = 1'b0;

    case (state)
      IDLE: begin
        cnt_next = '0;
        if (!line) begin
          state_next = START;
        end
      end

      START: begin
        if (cnt == HALF_LAST) begin
          cnt_next = '0;
          if (line) begin
            state_next = IDLE;
          end else begin
            state_next   = DATA;
            bit_idx_next = '0;
          end
        end
      end

      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_next   = '0;
          shift_next = {line, shift[7:1]};
          if (bit_idx == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
          end
        end
      end

      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_next = '0;
          if (line) begin
            rx_byte_next  = shift;
            new_byte_next = 1'b1;
            state_next    = IDLE;
          end else begin
            ferr_next  = 1'b1;
            state_next = WAIT_IDLE;
          end
        end
      end

      WAIT_IDLE: begin
        cnt_next = '0;
        if (line) begin
          state_next = IDLE;
        end
      end

      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed self-checking bench for uart_receiver at BIT_PERIOD=16, HALF_PERIOD=8.
// Inputs change 1 ns after the rising edge; strobes are observed on the falling edge.
module tb_uart_receiver;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 100_000;
  localparam int BIT      = 16;
  localparam int HALF     = 8;
  // Two synchroniser stages plus IDLE + HALF + 9*BIT + 1.
  localparam int LATENCY  = 2 + HALF + 9 * BIT + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       uart_rx = 1'b1;
  logic [7:0] rx_byte;
  logic       rx_new_byte;
  logic       framing_error;
  logic       rx_busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int new_count = 0;
  int ferr_count = 0;
  int both_count = 0;
  int strobe_cyc = 0;
  int prev_strobe_cyc = 0;
  logic [7:0] strobe_byte = 8'h00;

  uart_receiver #(
    .comm_clk_frequency (CLK_FREQ),
    .baud_rate          (BAUD)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .uart_rx       (uart_rx),
    .rx_byte       (rx_byte),
    .rx_new_byte   (rx_new_byte),
    .framing_error (framing_error),
    .rx_busy       (rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Record every strobe with the cycle it appeared in.
  always @(negedge clk) begin
    if (rx_new_byte) begin
      new_count++;
      prev_strobe_cyc = strobe_cyc;
      strobe_cyc      = cyc;
      strobe_byte     = rx_byte;
    end
    if (framing_error) ferr_count++;
    if (rx_new_byte && framing_error) both_count++;
  end

  task automatic drive(input logic v, input int n);
    uart_rx = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_frame(input logic [7:0] b, input int period, input int idle_after);
    drive(1'b0, period);
    for (int i = 0; i < 8; i++) drive(b[i], period);
    drive(1'b1, period);
    drive(1'b1, idle_after);
  endtask

  task automatic test_reset;
    reset   = 1'b1;
    uart_rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (rx_byte !== 8'h00) begin errors++; $display("[TB] FAIL reset_rx_byte: got %h expected 00", rx_byte); end
    checks++; if (rx_new_byte !== 1'b0) begin errors++; $display("[TB] FAIL reset_new_byte: got %b expected 0", rx_new_byte); end
    checks++; if (framing_error !== 1'b0) begin errors++; $display("[TB] FAIL reset_ferr: got %b expected 0", framing_error); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", rx_busy); end
    drive(1'b1, BIT);
  endtask

  task automatic test_single_frame;
    logic [7:0] b;
    int n0, f0, start;
    b = 8'h55;
    n0 = new_count;
    f0 = ferr_count;
    start = cyc;
    drive(1'b0, HALF);
    checks++; if (rx_busy !== 1'b1) begin errors++; $display("[TB] FAIL frame55_busy_start: got %b expected 1", rx_busy); end
    drive(1'b0, BIT - HALF);
    for (int i = 0; i < 8; i++) begin
      drive(b[i], HALF);
      checks++; if (rx_busy !== 1'b1) begin errors++; $display("[TB] FAIL frame55_busy_bit%0d: got %b expected 1", i, rx_busy); end
      drive(b[i], BIT - HALF);
    end
    drive(1'b1, HALF);
    checks++; if (rx_busy !== 1'b1) begin errors++; $display("[TB] FAIL frame55_busy_stop: got %b expected 1", rx_busy); end
    drive(1'b1, BIT - HALF);
    drive(1'b1, BIT);
    checks++; if (new_count - n0 !== 1) begin errors++; $display("[TB] FAIL frame55_strobes: got %0d expected 1", new_count - n0); end
    checks++; if (strobe_byte !== 8'h55) begin errors++; $display("[TB] FAIL frame55_strobe_byte: got %h expected 55", strobe_byte); end
    checks++; if (rx_byte !== 8'h55) begin errors++; $display("[TB] FAIL frame55_rx_byte: got %h expected 55", rx_byte); end
    checks++; if (strobe_cyc - start !== LATENCY) begin errors++; $display("[TB] FAIL frame55_latency: got %0d expected %0d", strobe_cyc - start, LATENCY); end
    checks++; if (ferr_count - f0 !== 0) begin errors++; $display("[TB] FAIL frame55_ferr: got %0d expected 0", ferr_count - f0); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("[TB] FAIL frame55_busy_after: got %b expected 0", rx_busy); end
  endtask

  task automatic test_glitch;
    int n0, f0;
    n0 = new_count;
    f0 = ferr_count;
    drive(1'b0, 4);
    checks++; if (rx_busy !== 1'b1) begin errors++; $display("[TB] FAIL glitch_busy_rise: got %b expected 1", rx_busy); end
    drive(1'b1, 9);
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("[TB] FAIL glitch_busy_fall: got %b expected 0", rx_busy); end
    drive(1'b1, BIT);
    checks++; if (new_count - n0 !== 0) begin errors++; $display("[TB] FAIL glitch_strobes: got %0d expected 0", new_count - n0); end
    checks++; if (ferr_count - f0 !== 0) begin errors++; $display("[TB] FAIL glitch_ferr: got %0d expected 0", ferr_count - f0); end
    checks++; if (rx_byte !== 8'h55) begin errors++; $display("[TB] FAIL glitch_rx_byte: got %h expected 55", rx_byte); end
  endtask

  task automatic test_back_to_back;
    int n0, f0;
    n0 = new_count;
    f0 = ferr_count;
    apply_frame(8'hA3, BIT, 0);
    drive(1'b0, BIT);
    checks++; if (new_count - n0 !== 1) begin errors++; $display("[TB] FAIL b2b_first_strobe: got %0d expected 1", new_count - n0); end
    checks++; if (rx_byte !== 8'hA3) begin errors++; $display("[TB] FAIL b2b_first_byte: got %h expected a3", rx_byte); end
    for (int i = 0; i < 8; i++) drive(1'b1, BIT);
    drive(1'b1, BIT);
    drive(1'b1, 2 * BIT);
    checks++; if (new_count - n0 !== 2) begin errors++; $display("[TB] FAIL b2b_strobes: got %0d expected 2", new_count - n0); end
    checks++; if (rx_byte !== 8'hFF) begin errors++; $display("[TB] FAIL b2b_second_byte: got %h expected ff", rx_byte); end
    checks++; if (strobe_cyc - prev_strobe_cyc !== 10 * BIT) begin errors++; $display("[TB] FAIL b2b_spacing: got %0d expected %0d", strobe_cyc - prev_strobe_cyc, 10 * BIT); end
    checks++; if (ferr_count - f0 !== 0) begin errors++; $display("[TB] FAIL b2b_ferr: got %0d expected 0", ferr_count - f0); end
  endtask

  task automatic test_break;
    int n0, f0;
    n0 = new_count;
    f0 = ferr_count;
    drive(1'b0, 20 * BIT);
    checks++; if (rx_busy !== 1'b1) begin errors++; $display("[TB] FAIL break_busy_held: got %b expected 1", rx_busy); end
    checks++; if (ferr_count - f0 !== 1) begin errors++; $display("[TB] FAIL break_ferr: got %0d expected 1", ferr_count - f0); end
    checks++; if (new_count - n0 !== 0) begin errors++; $display("[TB] FAIL break_strobes: got %0d expected 0", new_count - n0); end
    checks++; if (rx_byte !== 8'hFF) begin errors++; $display("[TB] FAIL break_rx_byte: got %h expected ff", rx_byte); end
    drive(1'b1, 2 * BIT);
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("[TB] FAIL break_busy_release: got %b expected 0", rx_busy); end
    apply_frame(8'h7E, BIT, BIT);
    checks++; if (new_count - n0 !== 1) begin errors++; $display("[TB] FAIL break_after_strobes: got %0d expected 1", new_count - n0); end
    checks++; if (rx_byte !== 8'h7E) begin errors++; $display("[TB] FAIL break_after_byte: got %h expected 7e", rx_byte); end
    checks++; if (ferr_count - f0 !== 1) begin errors++; $display("[TB] FAIL break_after_ferr: got %0d expected 1", ferr_count - f0); end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] b;
    int n0, f0;
    b = 8'h3C;
    n0 = new_count;
    f0 = ferr_count;
    drive(1'b0, BIT);
    for (int i = 0; i < 4; i++) drive(b[i], BIT);
    drive(b[4], HALF);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++; if (rx_byte !== 8'h00) begin errors++; $display("[TB] FAIL midreset_rx_byte: got %h expected 00", rx_byte); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy: got %b expected 0", rx_busy); end
    checks++; if (rx_new_byte !== 1'b0) begin errors++; $display("[TB] FAIL midreset_new_byte: got %b expected 0", rx_new_byte); end
    checks++; if (framing_error !== 1'b0) begin errors++; $display("[TB] FAIL midreset_ferr_out: got %b expected 0", framing_error); end
    // The sender abandons the interrupted frame and idles the line.
    drive(1'b1, 4 * BIT);
    checks++; if (new_count - n0 !== 0) begin errors++; $display("[TB] FAIL midreset_strobes: got %0d expected 0", new_count - n0); end
    checks++; if (ferr_count - f0 !== 0) begin errors++; $display("[TB] FAIL midreset_ferr: got %0d expected 0", ferr_count - f0); end
    apply_frame(8'h81, BIT, BIT);
    checks++; if (new_count - n0 !== 1) begin errors++; $display("[TB] FAIL midreset_after_strobes: got %0d expected 1", new_count - n0); end
    checks++; if (rx_byte !== 8'h81) begin errors++; $display("[TB] FAIL midreset_after_byte: got %h expected 81", rx_byte); end
  endtask

  task automatic test_baud_tolerance;
    int n0, f0;
    int periods [2];
    periods[0] = BIT + 1;
    periods[1] = BIT - 1;
    for (int k = 0; k < 2; k++) begin
      n0 = new_count;
      f0 = ferr_count;
      apply_frame(8'hC5, periods[k], 2 * BIT);
      checks++; if (new_count - n0 !== 1) begin errors++; $display("[TB] FAIL tol%0d_strobes: got %0d expected 1", periods[k], new_count - n0); end
      checks++; if (strobe_byte !== 8'hC5) begin errors++; $display("[TB] FAIL tol%0d_byte: got %h expected c5", periods[k], strobe_byte); end
      checks++; if (ferr_count - f0 !== 0) begin errors++; $display("[TB] FAIL tol%0d_ferr: got %0d expected 0", periods[k], ferr_count - f0); end
    end
  endtask

  task automatic test_exclusive_strobes;
    checks++; if (both_count !== 0) begin errors++; $display("[TB] FAIL strobes_overlap: got %0d expected 0", both_count); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_glitch();
    test_back_to_back();
    test_break();
    test_reset_mid_frame();
    test_baud_tolerance();
    test_exclusive_strobes();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
